// File: rtl/ddr_rd_responder.sv
// ddr_rd_responder: memory-side end of the DDR read interface, backed by a
// preloadable word array and returning in-order data after a fixed latency.
module ddr_rd_responder #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int ADDR_SHIFT      = 9,
    parameter int DEPTH           = 128,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ddr_rd,
    input  logic [ADDR_WIDTH-1:0]                  readAdd,
    output logic                                   ddr_rd_done,
    output logic                                   ddr_rd_valid,
    output logic [DATA_WIDTH-1:0]                  ddr_rd_data,
    output logic                                   ddr_rd_err,
    input  logic                                   wr_en,
    input  logic [ADDR_WIDTH-1:0]                  wr_addr,
    input  logic [DATA_WIDTH-1:0]                  wr_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_word;
    logic [ADDR_WIDTH-1:0] wr_word;
    logic                  rd_oor;
    logic                  wr_oor;
    logic [IW-1:0]         rd_idx;
    logic [IW-1:0]         wr_idx;

    logic                  ready;
    logic [OW-1:0]         cnt_q;
    logic [OW-1:0]         cnt_d;

    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    vld_d;
    logic [LATENCY-1:0]    err_q;
    logic [LATENCY-1:0]    err_d;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];
    logic [DATA_WIDTH-1:0] dat_d [LATENCY];

    // Range checks use the full shifted address so aliasing can never occur.
    assign rd_word = readAdd >> ADDR_SHIFT;
    assign wr_word = wr_addr >> ADDR_SHIFT;
    assign rd_oor  = rd_word >= ADDR_WIDTH'(DEPTH);
    assign wr_oor  = wr_word >= ADDR_WIDTH'(DEPTH);
    assign rd_idx  = rd_word[IW-1:0];
    assign wr_idx  = wr_word[IW-1:0];

    assign ready       = (cnt_q < OW'(MAX_OUTSTANDING)) && rst;
    assign ddr_rd_done = ddr_rd && ready;

    always_ff @(posedge clk) begin
        if (wr_en && !wr_oor) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Stage 0 captures the array word at the accept edge, giving read-first
    // behaviour against a write landing on the same edge.
    always_comb begin
        vld_d = '0;
        err_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            dat_d[i] = '0;
        end
        vld_d[0] = ddr_rd_done;
        err_d[0] = ddr_rd_done && rd_oor;
        dat_d[0] = rd_oor ? '0 : mem_q[rd_idx];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Data stages only load on a valid entry so the output holds its last word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                if (vld_d[i]) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ddr_rd_done && !ddr_rd_valid) begin
            cnt_d = cnt_q + OW'(1);
        end else if (!ddr_rd_done && ddr_rd_valid) begin
            cnt_d = cnt_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding  = cnt_q;
    assign ddr_rd_valid = vld_q[LATENCY-1];
    assign ddr_rd_err   = err_q[LATENCY-1];
    assign ddr_rd_data  = dat_q[LATENCY-1];

endmodule
